// File: rtl/data_ram_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : data_ram_ctrl
// Description : Load/store data RAM with byte enables, write-first forwarding,
//               and sticky/saturating error tracking for bad accesses.
// Revision    : 1.0 - initial release
// ============================================================================
module data_ram_ctrl #(
    parameter logic [31:0] BASE  = 32'h0001_0000,
    parameter int          AW    = 10,
    parameter int          CNT_W = 8
) (
    input  logic             CLK,
    input  logic             rst,
    input  logic [31:0]      RADDR,
    input  logic [1:0]       RWHBS,
    input  logic [31:0]      WADDR,
    input  logic [31:0]      WData,
    input  logic [1:0]       WWHBS,
    input  logic             WE,
    output logic [31:0]      RAMData,
    output logic             RErr,
    output logic             WErr,
    output logic [CNT_W-1:0] RErrCnt,
    output logic [CNT_W-1:0] WErrCnt,
    input  logic             ErrClr
);

    localparam logic [32:0] c_WIN_BYTES = 33'd4 << AW;
    localparam int          c_WORDS     = 1 << AW;

    function automatic logic size_ok(input logic [1:0] sz, input logic [1:0] lane);
        case (sz)
            2'b00:   size_ok = 1'b1;
            2'b01:   size_ok = ~lane[0];
            2'b10:   size_ok = (lane == 2'b00);
            default: size_ok = 1'b0;
        endcase
    endfunction

    logic [31:0]      r_mem [c_WORDS];
    logic [31:0]      r_ramdata;
    logic             r_rerr;
    logic             r_werr;
    logic [CNT_W-1:0] r_rcnt;
    logic [CNT_W-1:0] r_wcnt;
    logic             r_prev_vld;
    logic [31:0]      r_prev_addr;
    logic [1:0]       r_prev_sz;

    logic [31:0]      w_roff;
    logic [31:0]      w_woff;
    logic [AW-1:0]    w_ridx;
    logic [AW-1:0]    w_widx;
    logic [1:0]       w_rlane;
    logic [1:0]       w_wlane;
    logic             w_rok;
    logic             w_wok;
    logic             w_wen;
    logic [3:0]       w_be;
    logic [31:0]      w_wrep;
    logic [31:0]      w_rword;
    logic [31:0]      w_shift;
    logic [31:0]      w_rval;
    logic             w_rnew;
    logic             w_rfault;
    logic             w_wfault;

    // Offsets wrap modulo 2^32, so addresses below BASE land far out of window.
    assign w_roff  = RADDR - BASE;
    assign w_woff  = WADDR - BASE;
    assign w_rlane = w_roff[1:0];
    assign w_wlane = w_woff[1:0];
    assign w_ridx  = w_roff[AW+1:2];
    assign w_widx  = w_woff[AW+1:2];
    assign w_rok   = ({1'b0, w_roff} < c_WIN_BYTES) && size_ok(RWHBS, w_rlane);
    assign w_wok   = ({1'b0, w_woff} < c_WIN_BYTES) && size_ok(WWHBS, w_wlane);
    assign w_wen   = WE && w_wok && !rst;

    always_comb begin
        w_be   = 4'b1111;
        w_wrep = WData;
        case (WWHBS)
            2'b00: begin
                w_be   = 4'b0001 << w_wlane;
                w_wrep = {4{WData[7:0]}};
            end
            2'b01: begin
                w_be   = 4'b0011 << w_wlane;
                w_wrep = {2{WData[15:0]}};
            end
            default: begin
                w_be   = 4'b1111;
                w_wrep = WData;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (w_wen) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) r_mem[w_widx][8*b +: 8] <= w_wrep[8*b +: 8];
            end
        end
    end

    // Write-first: same-word stores forward only their enabled bytes.
    always_comb begin
        w_rword = r_mem[w_ridx];
        if (w_wen && (w_widx == w_ridx)) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) w_rword[8*b +: 8] = w_wrep[8*b +: 8];
            end
        end
    end

    assign w_shift = w_rword >> {w_rlane, 3'b000};

    always_comb begin
        w_rval = 32'h0;
        if (w_rok) begin
            case (RWHBS)
                2'b00:   w_rval = {24'h0, w_shift[7:0]};
                2'b01:   w_rval = {16'h0, w_shift[15:0]};
                default: w_rval = w_shift;
            endcase
        end
    end

    assign w_rnew   = !r_prev_vld || (RADDR != r_prev_addr) || (RWHBS != r_prev_sz);
    assign w_rfault = !w_rok && w_rnew;
    assign w_wfault = WE && !w_wok;

    always_ff @(posedge CLK) begin
        if (rst) begin
            r_ramdata   <= 32'h0;
            r_prev_vld  <= 1'b0;
            r_prev_addr <= 32'h0;
            r_prev_sz   <= 2'b00;
        end else begin
            r_ramdata   <= w_rval;
            r_prev_vld  <= 1'b1;
            r_prev_addr <= RADDR;
            r_prev_sz   <= RWHBS;
        end
    end

    always_ff @(posedge CLK) begin
        if (rst || ErrClr) begin
            r_rerr <= 1'b0;
            r_werr <= 1'b0;
            r_rcnt <= '0;
            r_wcnt <= '0;
        end else begin
            if (w_rfault) r_rerr <= 1'b1;
            if (w_wfault) r_werr <= 1'b1;
            if (w_rfault && (r_rcnt != '1)) r_rcnt <= r_rcnt + CNT_W'(1);
            if (w_wfault && (r_wcnt != '1)) r_wcnt <= r_wcnt + CNT_W'(1);
        end
    end

    assign RAMData = r_ramdata;
    assign RErr    = r_rerr;
    assign WErr    = r_werr;
    assign RErrCnt = r_rcnt;
    assign WErrCnt = r_wcnt;

endmodule
`default_nettype wire
